helical_nand_ring: RTL

HELICAL_NAND_RING -- requirements
Module: helical_nand_ring

---
 rtl/helical_nand_ring_if.sv | 29 ++
 rtl/helical_nand_ring.sv | 132 +++++++++++++
 2 files changed

// File: rtl/helical_nand_ring_if.sv
// helical_nand_ring_if: breath request/result bundle for helical_nand_ring.
interface helical_nand_ring_if #(
    parameter int NUM_CELLS  = 8,
    parameter int PHASE_BITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_CELLS-1:0]  in_data;
    logic [PHASE_BITS-1:0] phase_offset;
    logic                  abort;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM_CELLS-1:0]  out_data;
    logic [NUM_CELLS-1:0]  out_remainders;
    logic                  out_violation;
    logic [PHASE_BITS-1:0] out_phase;
    logic                  breath_complete;
    logic [7:0]            viol_count;
    modport master (
        output in_valid, in_data, phase_offset, abort, out_ready,
        input  in_ready, out_valid, out_data, out_remainders, out_violation,
               out_phase, breath_complete, viol_count
    );
    modport slave (
        input  in_valid, in_data, phase_offset, abort, out_ready,
        output in_ready, out_valid, out_data, out_remainders, out_violation,
               out_phase, breath_complete, viol_count
    );
endinterface

// File: rtl/helical_nand_ring.sv
// helical_nand_ring: breath-sequenced NAND helix (inhale one cell per cycle, hold, exhale result).
// Define HELIX_VIOLATION_COUNT_EN to build the saturating violating-breath counter.
module helical_nand_ring #(
    parameter int NUM_CELLS   = 8,
    parameter int PHASE_BITS  = 3,
    parameter int HOLD_CYCLES = 2
) (
    input logic                clk,
    input logic                rst_n,
    helical_nand_ring_if.slave bus
);
    localparam int CW = $clog2(NUM_CELLS);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INHALE = 3'd1;
    localparam logic [2:0] HOLD   = 3'd2;
    localparam logic [2:0] EXHALE = 3'd3;
    localparam logic [2:0] REST   = 3'd4;
    localparam logic [CW-1:0] LAST_C = CW'(NUM_CELLS - 1);
    localparam logic [3:0]    LAST_H = 4'(HOLD_CYCLES - 1);

    logic [2:0]            st_q, st_d;
    logic [CW-1:0]         c_q, c_d;
    logic [3:0]            h_q, h_d;
    logic [NUM_CELLS-1:0]  d_q, d_d, sig_q, sig_d, rem_q, rem_d, viol_q, viol_d;
    logic [PHASE_BITS-1:0] off_q, off_d;
    logic [PHASE_BITS-1:0] phase_q [NUM_CELLS];
    logic [PHASE_BITS-1:0] phase_d [NUM_CELLS];
    logic                  bc_q, bc_d;
    logic                  prev, clr, done;
    logic [31:0]           ph_sum;

    always_comb begin
        prev   = (c_q == '0) ? 1'b1 : sig_q[c_q - 1'b1];
        ph_sum = 32'(off_q) + 32'(c_q) + 32'd1;
        done   = (st_q == EXHALE) && bus.out_ready && !bus.abort;
        clr    = (bus.abort && st_q != IDLE) || st_q == REST;
        st_d   = st_q;
        c_d    = c_q;
        h_d    = h_q;
        d_d    = d_q;
        off_d  = off_q;
        sig_d  = sig_q;
        rem_d  = rem_q;
        viol_d = viol_q;
        phase_d = phase_q;
        case (st_q)
            IDLE: if (bus.in_valid) begin
                st_d  = INHALE;
                c_d   = '0;
                d_d   = bus.in_data;
                off_d = bus.phase_offset;
            end
            INHALE: begin
                sig_d[c_q]   = ~(prev & d_q[c_q]);
                rem_d[c_q]   = prev & d_q[c_q];
                viol_d[c_q]  = ~prev & ~d_q[c_q];
                phase_d[c_q] = ph_sum[PHASE_BITS-1:0];
                c_d          = c_q + 1'b1;
                if (c_q == LAST_C) begin
                    st_d = HOLD;
                    h_d  = '0;
                end
            end
            HOLD: begin
                h_d  = h_q + 4'd1;
                st_d = (h_q == LAST_H) ? EXHALE : HOLD;
            end
            EXHALE: st_d = done ? REST : EXHALE;
            default: st_d = IDLE;
        endcase
        // Abort and the REST cycle share one clearing path so a dropped breath leaves no residue.
        if (clr) begin
            st_d   = IDLE;
            c_d    = '0;
            h_d    = '0;
            sig_d  = '0;
            rem_d  = '0;
            viol_d = '0;
            for (int i = 0; i < NUM_CELLS; i++) phase_d[i] = '0;
        end
        bc_d = done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            c_q    <= '0;
            h_q    <= '0;
            d_q    <= '0;
            off_q  <= '0;
            sig_q  <= '0;
            rem_q  <= '0;
            viol_q <= '0;
            bc_q   <= 1'b0;
            for (int i = 0; i < NUM_CELLS; i++) phase_q[i] <= '0;
        end else begin
            st_q    <= st_d;
            c_q     <= c_d;
            h_q     <= h_d;
            d_q     <= d_d;
            off_q   <= off_d;
            sig_q   <= sig_d;
            rem_q   <= rem_d;
            viol_q  <= viol_d;
            bc_q    <= bc_d;
            phase_q <= phase_d;
        end
    end

`ifdef HELIX_VIOLATION_COUNT_EN
    logic [7:0] vc_q, vc_d;

    always_comb vc_d = (done && |viol_q && vc_q != 8'hFF) ? vc_q + 8'd1 : vc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vc_q <= '0;
        else vc_q <= vc_d;
    end

    assign bus.viol_count = vc_q;
`else
    assign bus.viol_count = '0;
`endif

    assign bus.in_ready        = st_q == IDLE;
    assign bus.out_valid       = st_q == EXHALE;
    assign bus.out_data        = sig_q;
    assign bus.out_remainders  = rem_q;
    assign bus.out_violation   = |viol_q;
    assign bus.out_phase       = phase_q[NUM_CELLS-1];
    assign bus.breath_complete = bc_q;
endmodule
